// File: rtl/seq_chk_pkg.sv
// Shared types and helpers for the multi-channel sequence checker.
// A verdict lands 1 + max(D1, D2) edges after the trigger edge.
package seq_chk_pkg;

    typedef enum logic {
        SEQ_AND = 1'b0,
        SEQ_OR  = 1'b1
    } seq_mode_e;

    localparam int MAX_DLY = 15;

    function automatic int seq_lat(input int d1, input int d2);
        return 1 + ((d1 > d2) ? d1 : d2);
    endfunction

endpackage

// File: rtl/seq_chk_lane.sv
// One checker channel: rise detection, sample histories, registered verdict
// and saturating pass/fail counters.
module seq_chk_lane
    import seq_chk_pkg::*;
#(
    parameter int D1    = 1,
    parameter int D2    = 2,
    parameter int MODE  = 0,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr_cnt,
    input  logic             start,
    input  logic             a,
    input  logic             b,
    input  logic             stop,
    output logic             pass,
    output logic             fail,
    output logic             fail_nxt,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
);

    localparam int LAT = seq_lat(D1, D2);
    localparam seq_mode_e MODE_E = (MODE == 1) ? SEQ_OR : SEQ_AND;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             start_q, start_d;
    logic [LAT-1:0]   trig_q, trig_d;
    logic [LAT:0]     trig_win;
    logic             trig, due, s1, s2, match;
    logic             pass_q, pass_d, fail_q, fail_d;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d;
    logic [2:0]       sig_now, smp;

    assign sig_now = {stop, b, a};

    // Each input is kept only as far back as its sample point lies from the
    // verdict edge; an age of zero means the live value is the sample.
    for (genvar g = 0; g < 3; g++) begin : g_smp
        localparam int AGE = (g == 0) ? LAT - 1 - D1 :
                             (g == 1) ? LAT - 1 : LAT - 1 - D2;
        if (AGE == 0) begin : g_now
            assign smp[g] = sig_now[g];
        end else begin : g_hist
            logic [AGE-1:0] hist_q, hist_d;
            logic [AGE:0]   win;
            always_comb begin
                win    = {hist_q, sig_now[g]};
                hist_d = win[AGE-1:0];
            end
            always_ff @(posedge clk or posedge rst) begin
                if (rst) hist_q <= '0;
                else     hist_q <= hist_d;
            end
            assign smp[g] = win[AGE];
        end
    end

    always_comb begin
        start_d  = start;
        trig     = start & ~start_q & en;
        trig_win = {trig_q, trig};
        trig_d   = trig_win[LAT-1:0];
        due      = trig_win[LAT];
        s1       = smp[0];
        s2       = smp[1] & smp[2];
        match    = (MODE_E == SEQ_OR) ? (s1 | s2) : (s1 & s2);
        pass_d   = due & match;
        fail_d   = due & ~match;

        // A clear on the same edge as a verdict leaves the counter at zero.
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        if (clr_cnt) begin
            pass_cnt_d = '0;
            fail_cnt_d = '0;
        end else begin
            if (pass_d && (pass_cnt_q != CNT_MAX)) pass_cnt_d = pass_cnt_q + CNT_W'(1);
            if (fail_d && (fail_cnt_q != CNT_MAX)) fail_cnt_d = fail_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q    <= 1'b0;
            trig_q     <= '0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            start_q    <= start_d;
            trig_q     <= trig_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    assign pass     = pass_q;
    assign fail     = fail_q;
    assign fail_nxt = fail_d;
    assign pass_cnt = pass_cnt_q;
    assign fail_cnt = fail_cnt_q;

endmodule

// File: rtl/seq_and_checker.sv
// Multi-channel monitor for rose(start) |=> (##D1 a) and/or (b ##D2 stop),
// one lane per channel plus a sticky flag raised by any channel failure.
module seq_and_checker
    import seq_chk_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int D1    = 1,
    parameter int D2    = 2,
    parameter int MODE  = 0,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr_cnt,
    input  logic [N_CH-1:0]       start,
    input  logic [N_CH-1:0]       a,
    input  logic [N_CH-1:0]       b,
    input  logic [N_CH-1:0]       stop,
    output logic [N_CH-1:0]       pass,
    output logic [N_CH-1:0]       fail,
    output logic [N_CH*CNT_W-1:0] pass_cnt,
    output logic [N_CH*CNT_W-1:0] fail_cnt,
    output logic                  any_fail
);

    logic [N_CH-1:0] fail_nxt;
    logic            any_fail_q, any_fail_d;

    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        seq_chk_lane #(
            .D1    (D1),
            .D2    (D2),
            .MODE  (MODE),
            .CNT_W (CNT_W)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .clr_cnt  (clr_cnt),
            .start    (start[i]),
            .a        (a[i]),
            .b        (b[i]),
            .stop     (stop[i]),
            .pass     (pass[i]),
            .fail     (fail[i]),
            .fail_nxt (fail_nxt[i]),
            .pass_cnt (pass_cnt[i*CNT_W +: CNT_W]),
            .fail_cnt (fail_cnt[i*CNT_W +: CNT_W])
        );
    end

    // The flag rises together with the fail pulse; a clear on that edge wins.
    always_comb begin
        any_fail_d = any_fail_q | (|fail_nxt);
        if (clr_cnt) any_fail_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) any_fail_q <= 1'b0;
        else     any_fail_q <= any_fail_d;
    end

    assign any_fail = any_fail_q;

endmodule

// File: doc/seq_and_checker.md
Name: seq_and_checker

Overview:
- Synthesizable, multi-channel RTL monitor for the property "rose(start) |=> (##D1 a) and (b ##D2 stop)", generalised in channel count, delays and combine mode (AND/OR).
- Tracks overlapping attempts per channel and issues one pass/fail verdict per attempt.
- Keeps saturating pass/fail counters and a sticky fail flag.
- Sits beside a DUT in simulation or emulation, replacing tool-only SVA checking.

Parameters:
- N_CH, 4, number of independent channels
- D1, 1, delay of `a` after the sequence start (0..15)
- D2, 2, delay of `stop` after `b` (0..15)
- MODE, 0, 0 = AND (both sub-sequences must match), 1 = OR (either may match)
- CNT_W, 16, width of each per-channel counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  trigger enable; low blocks new attempts, in-flight attempts still complete
- clr_cnt  in  1  synchronous clear of counters and any_fail
- start  in  N_CH  per-channel trigger source
- a  in  N_CH  sub-sequence 1 signal
- b  in  N_CH  sub-sequence 2 head
- stop  in  N_CH  sub-sequence 2 tail
- pass  out  N_CH  one-cycle verdict pulse, attempt matched
- fail  out  N_CH  one-cycle verdict pulse, attempt failed
- pass_cnt  out  N_CH*CNT_W  saturating pass counters; channel i occupies bits [i*CNT_W +: CNT_W]
- fail_cnt  out  N_CH*CNT_W  saturating fail counters, same packing
- any_fail  out  1  sticky; set by any fail pulse

Behaviour:
- Reset (async, rst=1): all registers clear. pass, fail, counters and any_fail = 0. start_q = 0. Every in-flight attempt is discarded and produces no verdict.
- Trigger:
  - Attempt launched at edge k when start=1 at k, start_q=0 (start at k-1) and en=1.
  - start held high after reset deasserts counts as a rise at the first edge.
- Sampling, relative to the trigger edge k:
  - b at edge k+1
  - a at edge k+1+D1
  - stop at edge k+1+D2
- Verdict latency: L = 1 + max(D1, D2).
  - pass/fail are registered and assert for exactly one cycle after edge k+L, even if a sub-sequence is already known to fail earlier.
  - Exactly one of pass/fail per attempt.
- Verdict logic:
  - s1 = a sample.
  - s2 = b sample AND stop sample.
  - MODE=0: pass = s1 & s2.
  - MODE=1: pass = s1 | s2.
  - fail = not pass.
- Overlap:
  - Attempts may launch every second edge (start must fall between rises).
  - Each attempt is evaluated independently from its own sampled history. Implement with per-channel shift histories of depth L for the trigger, a, b and stop; no state machine per attempt.
- Counters:
  - Increment on the same edge that registers the pulse.
  - Saturate at 2^CNT_W - 1.
  - clr_cnt wins over a simultaneous increment: result 0.
  - any_fail is cleared only by clr_cnt or rst. clr_cnt wins over a simultaneous fail.
- Reset mid-attempt: history cleared. No verdict for that attempt. The next rise after reset starts a fresh attempt.
- en low at a rise edge: no attempt, and that rise is lost. en has no effect on attempts already launched.
- D1 = D2 = 0: L = 1, and a, b, stop are all sampled at k+1.
- Channels are fully independent; simultaneous verdicts on several channels are all reported.

Decomposition:
- Package seq_chk_pkg:
  - mode enum: SEQ_AND = 0, SEQ_OR = 1
  - function seq_lat(d1, d2) returning 1 + max
  - MAX_DLY = 15 constant
- Sub-module seq_chk_lane: one channel, holding start_q, histories, verdict and counters.
- Top level: generate loop over N_CH lanes, plus the any_fail OR-reduction and sticky register.

Test Plan:
1. Reset mid-run, with start, a, b, stop toggling → all outputs 0 while rst is high; no verdict issued for an attempt launched 1 edge before rst.
2. D1=1, D2=2, MODE=0, ch0: start rises at edge 10, b=1 at 11, a=1 at 12, stop=1 at 13 → pass[0] high only after edge 13; pass_cnt[0]=1; fail[0]=0.
3. Same stimulus but a=0 at 12 → fail[0] after edge 13; any_fail=1; fail_cnt[0]=1. Rerun with MODE=1 → pass[0] instead.
4. Overlap: start rises at edges 10 and 12 on ch1, all signals 1 throughout → pass[1] after edges 13 and 15; pass_cnt[1]=2. ch2 idle → no pulses, counters stay 0.
5. CNT_W=2: five passing attempts on ch0 → pass_cnt[0]=3 (saturated). Then clr_cnt on the edge that registers a pass → pass_cnt[0]=0 and any_fail=0.
6. en=0 at the rise edge of ch3 → no verdict. Attempt launched with en=1, then en=0 before edge k+L → its verdict is still issued.
